// File: rtl/stq_pkg.sv
// Shared types and defaults for the store-queue gather block.
// Also supplies the block-level macros (lane count, value width, row index
// width, work-mode encoding) when the shared definitions header has not.
// Latency: n/a. Backpressure: n/a.
`ifndef STQ_DEFINITIONS_VH
`define STQ_DEFINITIONS_VH
`define NUM_UNITs      4
`define DATA_PRECISION 32
`define BITS_ROW_IDX   8
`define MODE_WORK      1'b1
`endif

package stq_pkg;

    localparam int STQ_DEPTH_DEF    = 8;
    localparam int STQ_AFULL_TH_DEF = STQ_DEPTH_DEF - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } stq_state_e;

endpackage

// File: rtl/stq_lane_fifo.sv
// Purpose: one lane of the gather queue; power-of-2 FIFO with extra-MSB pointers.
// Latency: a push is visible at o_head the cycle after the push; head is a
//          combinational read of storage. Backpressure: caller must not push when
//          full unless popping in the same cycle. Storage is not reset.
// Ports: clk/rst_b, i_push/i_push_dat, i_pop, o_head, o_empty, o_full, o_occupancy.
module stq_lane_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_dat,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic              o_empty,
    output logic              o_full,
    output logic [AW:0]       o_occupancy
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    assign o_head      = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty     = (r_wr_ptr == r_rd_ptr);
    // Full when the wrap bits differ but the index bits match.
    assign o_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_occupancy = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/stq_gather.sv
// Purpose: gathers per-lane unit results into wide beats; FLUSH drains partial beats.
// Latency: a value appears in stq_data the cycle after it is written (head is
//          combinational). Backpressure: stq_buff_full[j] at AFULL_TH; writes to a
//          full lane without a same-cycle pop are dropped and flagged in overflow.
// Ports: unit_* write side, stq_* beat side, total_beats/flush/beat_cnt/done job control.
module stq_gather
    import stq_pkg::*;
#(
    parameter int NUM_UNITS = `NUM_UNITs,
    parameter int DATA_W    = `DATA_PRECISION,
    parameter int ROW_W     = `BITS_ROW_IDX,
    parameter int DEPTH     = STQ_DEPTH_DEF,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic                        unit_en,
    input  logic                        mode,
    input  logic [NUM_UNITS-1:0]        unit_out_valid,
    input  logic [NUM_UNITS*ROW_W-1:0]  unit_out_row_idx,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_out_value,
    input  logic                        stq_ready,
    input  logic [CNT_W-1:0]            total_beats,
    input  logic                        flush,
    output logic [NUM_UNITS-1:0]        stq_buff_full,
    output logic                        stq_valid,
    output logic [NUM_UNITS*DATA_W-1:0] stq_data,
    output logic [NUM_UNITS-1:0]        stq_mask,
    output logic [NUM_UNITS-1:0]        overflow,
    output logic [CNT_W-1:0]            beat_cnt,
    output logic                        done
);

    localparam int AW = $clog2(DEPTH);

    stq_state_e                       r_state;
    stq_state_e                       w_state_nxt;
    logic [CNT_W-1:0]                 r_beat_cnt;
    logic                             r_done;
    logic [NUM_UNITS-1:0]             r_overflow;

    logic                             w_global_en;
    logic                             w_fire;
    logic                             w_final;
    logic                             w_drained;
    logic [NUM_UNITS-1:0]             w_empty;
    logic [NUM_UNITS-1:0]             w_full;
    logic [NUM_UNITS-1:0]             w_push;
    logic [NUM_UNITS-1:0]             w_pop;
    logic [NUM_UNITS-1:0]             w_ovf_set;
    logic [NUM_UNITS-1:0]             w_empty_after;
    logic [NUM_UNITS-1:0][DATA_W-1:0] w_head;
    logic [NUM_UNITS-1:0][AW:0]       w_occ;
    logic                             w_unused_row;

    // Row index is carried on the port for compatibility only.
    assign w_unused_row = ^unit_out_row_idx;

    assign w_global_en = unit_en && (mode == `MODE_WORK);
    assign w_fire      = stq_valid && stq_ready;
    assign w_final     = w_fire && (total_beats != '0) &&
                         (r_beat_cnt == total_beats - CNT_W'(1));
    assign w_drained   = &w_empty_after;

    genvar j;
    generate
        for (j = 0; j < NUM_UNITS; j++) begin : g_lane
            // A full lane can still take a write when the same cycle pops it.
            assign w_pop[j]     = w_fire && stq_mask[j] && !w_empty[j];
            assign w_push[j]    = w_global_en && unit_out_valid[j] && (!w_full[j] || w_pop[j]);
            assign w_ovf_set[j] = w_global_en && unit_out_valid[j] && !w_push[j];
            assign w_empty_after[j] = w_empty[j] || (w_pop[j] && (w_occ[j] == (AW+1)'(1)));
            assign stq_buff_full[j] = (w_occ[j] >= (AW+1)'(AFULL_TH));
            // Lane 0 occupies the MSBs; masked-off or empty lanes drive zero.
            assign stq_data[(NUM_UNITS-1-j)*DATA_W +: DATA_W] =
                (stq_mask[j] && !w_empty[j]) ? w_head[j] : '0;

            stq_lane_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk         (clk),
                .rst_b       (rst_b),
                .i_push      (w_push[j]),
                .i_push_dat  (unit_out_value[(NUM_UNITS-1-j)*DATA_W +: DATA_W]),
                .i_pop       (w_pop[j]),
                .o_head      (w_head[j]),
                .o_empty     (w_empty[j]),
                .o_full      (w_full[j]),
                .o_occupancy (w_occ[j])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_done     <= 1'b0;
            r_overflow <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_overflow <= r_overflow | w_ovf_set;
            if (w_fire)  r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (w_final) r_done     <= 1'b1;
        end
    end

    // Everything freezes while global_en is low; the final beat wins over flush.
    always_comb begin
        w_state_nxt = r_state;
        stq_valid   = 1'b0;
        stq_mask    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_global_en) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                stq_valid = w_global_en && (&(~w_empty));
                stq_mask  = '1;
                if (w_global_en) begin
                    if (w_final)    w_state_nxt = ST_DONE;
                    else if (flush) w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                stq_valid = w_global_en && (|(~w_empty));
                stq_mask  = ~w_empty;
                if (w_global_en) begin
                    if (w_final)        w_state_nxt = ST_DONE;
                    else if (w_drained) w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_DONE;
            end
        endcase
    end

    assign overflow = r_overflow;
    assign beat_cnt = r_beat_cnt;
    assign done     = r_done;

endmodule

// File: tb/tb_stq_gather.sv
module tb_stq_gather;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int RW = 8;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            unit_en;
    logic            mode;
    logic [N-1:0]    unit_out_valid;
    logic [N*RW-1:0] unit_out_row_idx;
    logic [N*W-1:0]  unit_out_value;
    logic            stq_ready;
    logic [CW-1:0]   total_beats;
    logic            flush;
    logic [N-1:0]    stq_buff_full;
    logic            stq_valid;
    logic [N*W-1:0]  stq_data;
    logic [N-1:0]    stq_mask;
    logic [N-1:0]    overflow;
    logic [CW-1:0]   beat_cnt;
    logic            done;

    always #5 clk = ~clk;

    stq_gather #(
        .NUM_UNITS (N), .DATA_W (W), .ROW_W (RW),
        .DEPTH (D), .AFULL_TH (AF), .CNT_W (CW)
    ) u_dut (
        .clk (clk), .rst_b (rst_b), .unit_en (unit_en), .mode (mode),
        .unit_out_valid (unit_out_valid), .unit_out_row_idx (unit_out_row_idx),
        .unit_out_value (unit_out_value), .stq_ready (stq_ready),
        .total_beats (total_beats), .flush (flush),
        .stq_buff_full (stq_buff_full), .stq_valid (stq_valid),
        .stq_data (stq_data), .stq_mask (stq_mask), .overflow (overflow),
        .beat_cnt (beat_cnt), .done (done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: one queue per lane plus job-level bookkeeping.
    // Phases: 0 idle, 1 gathering full beats, 2 draining partial beats, 3 finished.
    logic [W-1:0] mq [N][$];
    int           m_phase;
    int unsigned  m_beats;
    bit           m_done;
    bit [N-1:0]   m_ovf;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic bit m_work();
        return unit_en && mode;
    endfunction

    function automatic bit m_valid();
        int filled = 0;
        for (int j = 0; j < N; j++) if (mq[j].size() > 0) filled++;
        if (!m_work()) return 1'b0;
        if (m_phase == 1) return filled == N;
        if (m_phase == 2) return filled > 0;
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] m_mask();
        logic [N-1:0] m = '0;
        if (m_phase == 1) m = '1;
        if (m_phase == 2) for (int j = 0; j < N; j++) m[j] = (mq[j].size() > 0);
        return m;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < N; j++) mq[j].delete();
        m_phase = 0; m_beats = 0; m_done = 1'b0; m_ovf = '0;
    endtask

    task automatic compare_outputs();
        logic [N*W-1:0] ed = '0;
        logic [N-1:0]   ef = '0;
        logic [N-1:0]   em = m_mask();
        for (int j = 0; j < N; j++) begin
            if (em[j] && mq[j].size() > 0) ed[(N-1-j)*W +: W] = mq[j][0];
            ef[j] = (mq[j].size() >= AF);
        end
        chk("valid", stq_valid, m_valid());
        chk("mask", stq_mask, em);
        chk("data", stq_data, ed);
        chk("buff_full", stq_buff_full, ef);
        chk("overflow", overflow, m_ovf);
        chk("beat_cnt", beat_cnt, m_beats[CW-1:0]);
        chk("done", done, m_done);
    endtask

    task automatic model_update();
        bit           fire;
        bit           fin;
        bit           all_empty;
        logic [N-1:0] em;
        if (!rst_b) begin
            model_reset();
            return;
        end
        fire = m_valid() && stq_ready;
        em   = m_mask();
        fin  = fire && (total_beats != 0) &&
               ((m_beats % 65536) == ((int'(total_beats) - 1) % 65536));
        if (fire) for (int j = 0; j < N; j++)
            if (em[j] && mq[j].size() > 0) void'(mq[j].pop_front());
        all_empty = 1'b1;
        for (int j = 0; j < N; j++) if (mq[j].size() != 0) all_empty = 1'b0;
        if (m_work()) begin
            for (int j = 0; j < N; j++) if (unit_out_valid[j]) begin
                if (mq[j].size() < D) mq[j].push_back(unit_out_value[(N-1-j)*W +: W]);
                else m_ovf[j] = 1'b1;
            end
            case (m_phase)
                0: m_phase = 1;
                1: if (fin) m_phase = 3; else if (flush) m_phase = 2;
                2: if (fin) m_phase = 3; else if (all_empty) m_phase = 1;
                default: ;
            endcase
        end
        if (fire) m_beats = (m_beats + 1) % 65536;
        if (fin) m_done = 1'b1;
    endtask

    task automatic cycle();
        @(negedge clk);
        if (chk_en) compare_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_values();
        for (int j = 0; j < N; j++) unit_out_value[(N-1-j)*W +: W] = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_b = 1'b0; unit_en = 1'b0; mode = 1'b0; unit_out_valid = '0;
        unit_out_row_idx = '0; unit_out_value = '0; stq_ready = 1'b0;
        total_beats = '0; flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        cycle();
        chk("rst_valid", stq_valid, 0);
        chk("rst_mask", stq_mask, 0);
        chk("rst_full", stq_buff_full, 0);
        chk("rst_data", stq_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_cnt", beat_cnt, 0);
        chk("rst_done", done, 0);

        // Normal gather: 3 values per lane with the sink ready.
        rst_b = 1'b1; unit_en = 1'b1; mode = 1'b1;
        cycle();
        stq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            unit_out_valid = 4'hF; set_values(); cycle();
        end
        unit_out_valid = '0;
        repeat (4) cycle();
        chk("norm_cnt", beat_cnt, 3);

        // Backpressure on lane 2, then one write too many.
        stq_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            unit_out_valid = 4'b0100; set_values(); cycle();
            if (i == 5) chk("bp_full", stq_buff_full, 4'b0100);
        end
        chk("bp_ovf", overflow, 4'b0100);

        // Lane 1 full, then push and pop lane 1 in the same cycle.
        for (int i = 0; i < 8; i++) begin
            unit_out_valid = 4'b0010; set_values(); cycle();
        end
        unit_out_valid = 4'b1001; set_values(); cycle();
        chk("sim_valid", stq_valid, 1);
        stq_ready = 1'b1; unit_out_valid = 4'b0010; set_values(); cycle();
        unit_out_valid = '0;
        chk("sim_ovf", overflow, 4'b0100);
        chk("sim_full", stq_buff_full, 4'b0110);
        flush = 1'b1; cycle(); flush = 1'b0;
        repeat (10) cycle();

        // Partial flush with lanes 0 and 3 holding one entry each.
        stq_ready = 1'b0; unit_out_valid = 4'b1001; set_values(); cycle();
        unit_out_valid = '0; flush = 1'b1; cycle(); flush = 1'b0;
        chk("fl_valid", stq_valid, 1);
        chk("fl_mask", stq_mask, 4'b1001);
        chk("fl_mid", stq_data[95:32], 0);
        stq_ready = 1'b1; cycle();
        stq_ready = 1'b0; cycle();
        unit_out_valid = 4'hF; set_values(); cycle(); unit_out_valid = '0;
        chk("fl_run_mask", stq_mask, 4'hF);
        chk("fl_run_valid", stq_valid, 1);
        stq_ready = 1'b1; cycle();

        // Reset in the middle of a job with data buffered.
        rst_b = 1'b0; cycle(); rst_b = 1'b1; cycle();
        for (int i = 0; i < 6; i++) begin
            unit_out_valid = 4'hF; set_values(); cycle();
        end
        stq_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            unit_out_valid = 4'hF; set_values(); cycle();
        end
        unit_out_valid = '0;
        chk("mid_cnt", beat_cnt, 5);
        rst_b = 1'b0; cycle();
        chk("mid_valid", stq_valid, 0);
        chk("mid_mask", stq_mask, 0);
        chk("mid_full", stq_buff_full, 0);
        chk("mid_data", stq_data, 0);
        chk("mid_cnt0", beat_cnt, 0);
        chk("mid_done", done, 0);
        rst_b = 1'b1;

        // Job of 2 beats with 3 beats of data offered.
        total_beats = 16'd2; cycle();
        for (int i = 0; i < 3; i++) begin
            unit_out_valid = 4'hF; set_values(); cycle();
        end
        unit_out_valid = '0; stq_ready = 1'b1;
        cycle();
        chk("done_early", done, 0);
        cycle();
        chk("done_rise", done, 1);
        chk("done_valid", stq_valid, 0);
        repeat (3) cycle();
        chk("done_hold", done, 1);
        chk("done_cnt", beat_cnt, 2);

        // Randomized traffic, unlimited job then a bounded one.
        for (int r = 0; r < 2; r++) begin
            rst_b = 1'b0; cycle(); rst_b = 1'b1;
            total_beats = (r == 0) ? 16'd0 : 16'd37;
            for (int i = 0; i < 600; i++) begin
                unit_en        = ($urandom % 8) != 0;
                mode           = ($urandom % 10) != 0;
                unit_out_valid = 4'($urandom);
                set_values();
                unit_out_row_idx = $urandom;
                stq_ready      = ($urandom % 3) != 0;
                flush          = ($urandom % 25) == 0;
                rst_b          = ($urandom % 300) != 0;
                cycle();
            end
            rst_b = 1'b1; flush = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
